uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that lets NUM_REQ nibble sources share one Hamming (7,4) encoder and one UART transmitter.
- Sequences each transfer end to end: arbitrate, then encode, then load and start the transmitter, then wait for the frame to finish.
- Sits between user-side nibble producers and the existing tt_um_hamming_encoder_74 / tt_um_uart_transmitter instances in the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, grant index width, must equal clog2(NUM_REQ)
ENC_TIMEOUT, 8, max cycles waiting for enc_valid after enc_ena
BUSY_TIMEOUT, 4, max cycles waiting for tx_busy to rise after tx_start

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-source request, level, held until ack
req_data  input  4*NUM_REQ  nibble of source i at bits [4i+3:4i]
ack  output  NUM_REQ  one-cycle pulse to the source whose nibble was captured
enc_ena  output  1  one-cycle enable to the encoder
enc_data  output  4  nibble presented to the encoder
enc_code  input  7  encoder codeword
enc_valid  input  1  encoder codeword valid
tx_start  output  1  one-cycle start pulse to the UART transmitter
tx_data  output  8  {1'b0, codeword} to the transmitter
tx_busy  input  1  transmitter busy
grant_id  output  ID_W  index of the source currently being served
active  output  1  high in any state other than IDLE
err  output  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = NUM_REQ-1, so source 0 wins first; data registers cleared.
- Reset is asynchronous and may assert mid-transfer. The FSM returns to IDLE immediately. No ack or tx_start may be emitted in the reset cycle.
- FSM states are IDLE, ENCODE, LOAD, WAIT_BUSY, SEND.
- IDLE:
  - When any req bit is high, select the first set bit searching from pointer+1 with wrap-around.
  - Register its nibble into enc_data and set grant_id.
  - Pulse ack[grant] for that same cycle and pulse enc_ena.
  - Go to ENCODE.
  - Decision to ack: 1 cycle from req sampled high.
- ENCODE:
  - On enc_valid, register {1'b0, enc_code} into tx_data and go to LOAD.
  - If enc_valid is still absent after ENC_TIMEOUT cycles, set err and go to IDLE. The nibble is dropped and the pointer still advances.
- LOAD: pulse tx_start for exactly one cycle, go to WAIT_BUSY.
- WAIT_BUSY:
  - On tx_busy=1, go to SEND.
  - If tx_busy stays 0 for BUSY_TIMEOUT cycles, set err and go to IDLE.
- SEND:
  - On tx_busy=0, set pointer = grant_id and go to IDLE.
- tx_data holds its value from LOAD until the next capture in ENCODE. enc_data holds its value from IDLE capture until the next grant.
- Only one transfer is ever in flight.
- Requests arriving while not in IDLE are ignored until the FSM returns to IDLE; no queueing beyond req.
- A source dropping req before it is acked is simply not served.
- Simultaneous requests are served strictly round-robin. A continuously requesting source waits at most NUM_REQ-1 transfers.
- A req held high in the same cycle as its ack is treated as consumed. The source must deassert, or present a new nibble, by the next IDLE cycle, or it re-requests.
- Back-to-back transfers: minimum one IDLE cycle between tx_busy falling and the next ack.
- err is set only on a timeout and is cleared only by rst_n.
- active = (state != IDLE).

Test Plan:
- Reset, then req=4'b0001 with nibble 4'hB → ack[0] pulse; enc_ena pulse with enc_data=4'hB; after enc_valid with model code 7'h33: tx_start one cycle, tx_data=8'h33, grant_id=0; active falls 1 cycle after tx_busy falls.
- req=4'b1111 held continuously (re-asserted after each ack), nibbles 1,2,3,4 → acks and frames in order 0,1,2,3,0; never two acks within one transfer.
- Pointer=1 (last served source 1), req=4'b0011 → source 0 wins only after the wrap (order 0 then 1 on next grant is wrong; 0 served first since search starts at 2, wraps to 0).
- Encoder model never asserts enc_valid → err=1 after 8 cycles in ENCODE, FSM back to IDLE, no tx_start; next request is still served normally and err stays 1.
- Transmitter model never raises tx_busy → err=1 after 4 cycles in WAIT_BUSY, active=0.
- Assert rst_n=0 during SEND → all outputs 0 asynchronously, pointer reset; after release, a pending req=4'b0100 is acked within 1 cycle.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one Hamming (7,4) encoder and one UART transmitter
// among NUM_REQ nibble sources; one transfer in flight from grant to end of frame.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int ENC_TIMEOUT  = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   enc_ena,
    output logic [3:0]             enc_data,
    input  logic [6:0]             enc_code,
    input  logic                   enc_valid,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   active,
    output logic                   err
);

    localparam int MAX_TO = (ENC_TIMEOUT > BUSY_TIMEOUT) ? ENC_TIMEOUT : BUSY_TIMEOUT;
    localparam int CNT_W  = $clog2(MAX_TO + 1);

    typedef enum logic [2:0] {
        IDLE,
        ENCODE,
        LOAD,
        WAIT_BUSY,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [3:0]           enc_data_q, enc_data_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 enc_ena_q, enc_ena_d;
    logic                 tx_start_q, tx_start_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 pick_valid;
    logic [ID_W-1:0]      pick_idx;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Search starts just after the last served source, so the most recent winner ranks last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_valid && req[wrap_idx(ptr_q, i)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        enc_data_d = enc_data_q;
        tx_data_d  = tx_data_q;
        ack_d      = '0;
        enc_ena_d  = 1'b0;
        tx_start_d = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    enc_data_d = req_data[int'(pick_idx) * 4 +: 4];
                    ack_d      = NUM_REQ'(1) << pick_idx;
                    enc_ena_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = ENCODE;
                end
            end
            ENCODE: begin
                if (enc_valid) begin
                    tx_data_d  = {1'b0, enc_code};
                    tx_start_d = 1'b1;
                    state_d    = LOAD;
                end else if (cnt_q == CNT_W'(ENC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            // A transmitter that never starts still advances the pointer so no source starves.
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = SEND;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            grant_q    <= '0;
            enc_data_q <= '0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            enc_ena_q  <= 1'b0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            enc_data_q <= enc_data_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            enc_ena_q  <= enc_ena_d;
            tx_start_q <= tx_start_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack      = ack_q;
    assign enc_ena  = enc_ena_q;
    assign enc_data = enc_data_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
    assign active   = (state_q != IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: the initial block plays encoder and transmitter
// cycle by cycle, driving on the falling edge and sampling there too.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  ack;
    logic        enc_ena;
    logic [3:0]  enc_data;
    logic [6:0]  enc_code;
    logic        enc_valid;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [6:0] rr_code [4];

    uart_tx_scheduler #(
        .NUM_REQ(4),
        .ID_W(2),
        .ENC_TIMEOUT(8),
        .BUSY_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .enc_ena(enc_ena),
        .enc_data(enc_data),
        .enc_code(enc_code),
        .enc_valid(enc_valid),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ack"},      32'(ack),      32'h0);
        check_output({tag, "_enc_ena"},  32'(enc_ena),  32'h0);
        check_output({tag, "_enc_data"}, 32'(enc_data), 32'h0);
        check_output({tag, "_tx_start"}, 32'(tx_start), 32'h0);
        check_output({tag, "_tx_data"},  32'(tx_data),  32'h0);
        check_output({tag, "_grant_id"}, 32'(grant_id), 32'h0);
        check_output({tag, "_active"},   32'(active),   32'h0);
        check_output({tag, "_err"},      32'(err),      32'h0);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = '0;
        enc_valid = 1'b0;
        enc_code  = '0;
        tx_busy   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Called from an IDLE falling edge with req already driven; the ack must follow one edge later.
    task automatic wait_ack(input string tag, input int src, input logic [3:0] nib, input bit clear_req);
        int lat;
        int n;
        lat = 0;
        n   = 0;
        while (lat == 0 && n < 4) begin
            tick();
            n++;
            if (ack !== 4'h0) lat = n;
        end
        check_output({tag, "_ack_latency"}, 32'(lat),      32'd1);
        check_output({tag, "_ack"},         32'(ack),      32'h1 << src);
        check_output({tag, "_enc_ena"},     32'(enc_ena),  32'h1);
        check_output({tag, "_enc_data"},    32'(enc_data), 32'(nib));
        check_output({tag, "_grant_id"},    32'(grant_id), 32'(src));
        if (clear_req) req[src] = 1'b0;
    endtask

    task automatic finish_xfer(input string tag, input int src, input logic [6:0] code);
        tick();
        check_output({tag, "_ack_once"},    32'(ack),     32'h0);
        check_output({tag, "_enc_ena_one"}, 32'(enc_ena), 32'h0);
        enc_valid = 1'b1;
        enc_code  = code;
        tick();
        enc_valid = 1'b0;
        check_output({tag, "_tx_start"},  32'(tx_start), 32'h1);
        check_output({tag, "_tx_data"},   32'(tx_data),  32'({1'b0, code}));
        check_output({tag, "_grant_tx"},  32'(grant_id), 32'(src));
        tick();
        check_output({tag, "_tx_start_one"}, 32'(tx_start), 32'h0);
        tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output({tag, "_no_ack_send"}, 32'(ack),    32'h0);
            check_output({tag, "_active_send"}, 32'(active), 32'h1);
        end
        tx_busy = 1'b0;
        tick();
        check_output({tag, "_active_fall"}, 32'(active), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rr_code[0] = 7'h69;
        rr_code[1] = 7'h2A;
        rr_code[2] = 7'h43;
        rr_code[3] = 7'h4C;
        req_data   = '0;

        // Reset state, then a single transfer from source 0.
        rst_n     = 1'b0;
        req       = '0;
        enc_valid = 1'b0;
        enc_code  = '0;
        tx_busy   = 1'b0;
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        req      = 4'b0001;
        req_data = 16'h000B;
        wait_ack("single", 0, 4'hB, 1'b1);
        finish_xfer("single", 0, 7'h33);
        check_output("single_tx_hold", 32'(tx_data), 32'h33);

        // All sources requesting continuously: strict rotation 0,1,2,3,0.
        apply_reset();
        req_data = 16'h4321;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack("rr", k % 4, 4'((k % 4) + 1), 1'b0);
            finish_xfer("rr", k % 4, rr_code[k % 4]);
        end
        req = '0;

        // Pointer at 1: search begins at 2 and wraps, so source 0 beats source 1.
        req_data = 16'h0056;
        req      = 4'b0010;
        wait_ack("ptr_set", 1, 4'h5, 1'b1);
        finish_xfer("ptr_set", 1, 7'h05);
        req = 4'b0011;
        wait_ack("ptr_wrap", 0, 4'h6, 1'b1);
        finish_xfer("ptr_wrap", 0, 7'h36);
        wait_ack("ptr_next", 1, 4'h5, 1'b1);
        finish_xfer("ptr_next", 1, 7'h27);

        // Encoder never answers: eight cycles in ENCODE, then err and back to IDLE.
        req_data = 16'h0900;
        req      = 4'b0100;
        wait_ack("enc_to", 2, 4'h9, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_output("enc_to_active",   32'(active),   32'h1);
            check_output("enc_to_no_start", 32'(tx_start), 32'h0);
            check_output("enc_to_err_low",  32'(err),      32'h0);
        end
        tick();
        check_output("enc_to_idle",     32'(active),   32'h0);
        check_output("enc_to_err",      32'(err),      32'h1);
        check_output("enc_to_no_start", 32'(tx_start), 32'h0);
        req_data = 16'hC000;
        req      = 4'b1000;
        wait_ack("after_to", 3, 4'hC, 1'b1);
        finish_xfer("after_to", 3, 7'h1C);
        check_output("err_sticky", 32'(err), 32'h1);

        // Transmitter never goes busy: four cycles in WAIT_BUSY, then err.
        apply_reset();
        check_output("reset_err_clear", 32'(err), 32'h0);
        req_data = 16'h0002;
        req      = 4'b0001;
        wait_ack("busy_to", 0, 4'h2, 1'b1);
        tick();
        enc_valid = 1'b1;
        enc_code  = 7'h55;
        tick();
        enc_valid = 1'b0;
        check_output("busy_to_start", 32'(tx_start), 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("busy_to_active",  32'(active), 32'h1);
            check_output("busy_to_err_low", 32'(err),    32'h0);
        end
        tick();
        check_output("busy_to_idle",    32'(active),  32'h0);
        check_output("busy_to_err",     32'(err),     32'h1);
        check_output("busy_to_tx_hold", 32'(tx_data), 32'h55);

        // Asynchronous reset in SEND, with source 2 already waiting.
        apply_reset();
        req_data = 16'h0A70;
        req      = 4'b0010;
        wait_ack("rst_send", 1, 4'h7, 1'b1);
        tick();
        enc_valid = 1'b1;
        enc_code  = 7'h7E;
        tick();
        enc_valid = 1'b0;
        tick();
        tx_busy = 1'b1;
        tick();
        check_output("rst_send_in_send", 32'(active), 32'h1);
        req = 4'b0100;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        rst_n   = 1'b1;
        tx_busy = 1'b0;
        wait_ack("post_rst", 2, 4'hA, 1'b1);
        finish_xfer("post_rst", 2, 7'h2D);
        check_output("post_rst_err", 32'(err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
